// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
interface instr_fetch_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (output MemReq, output MemAddr, input MemAck, input MemRData);
  modport slave  (input MemReq, input MemAddr, output MemAck, output MemRData);
endinterface

// File: rtl/instr_fetch.sv
// Multicycle MIPS instruction fetch: samples the PC on Start, reads imem over req/ack
// with a bounded wait, latches IR and PC+4, and records misalignment/timeout faults.
//
// state | meaning
// IDLE  | waiting for Start; IR/NPC/IRValid hold the last fetch
// REQ   | MemReq high, waiting up to TIMEOUT cycles for MemAck
// DONE  | fetch complete, PCWE high for this one cycle
// FAULT | sticky fault; only Flush or reset leaves
module instr_fetch #(
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          PCIn,
  input  logic                 Start,
  input  logic                 Flush,
  instr_fetch_if.master        mem,
  output logic [31:0]          IR,
  output logic [31:0]          NPC,
  output logic                 PCWE,
  output logic                 IRValid,
  output logic                 Busy,
  output logic                 Fault,
  output logic [1:0]           FaultCause
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [7:0] WAIT_LAST     = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] ir_q;
  logic [31:0] npc_q;
  logic        pcwe_q;
  logic        ir_valid_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;
  logic [7:0]  wait_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      ir_q          <= '0;
      npc_q         <= '0;
      pcwe_q        <= 1'b0;
      ir_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      wait_cnt_q    <= '0;
    end else if (Flush) begin
      // IR, NPC and MemAddr deliberately hold across an abort
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      pcwe_q        <= 1'b0;
      ir_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
    end else begin
      pcwe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            ir_valid_q <= 1'b0;
            if (PCIn[1:0] == 2'b00) begin
              mem_addr_q <= PCIn;
              mem_req_q  <= 1'b1;
              wait_cnt_q <= '0;
              state_q    <= REQ;
            end else begin
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_ALIGN;
              state_q       <= FAULT;
            end
          end
        end
        REQ: begin
          // an ack on the final wait cycle still completes the fetch
          if (mem.MemAck) begin
            ir_q       <= mem.MemRData;
            npc_q      <= mem_addr_q + 32'd4;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b1;
            pcwe_q     <= 1'b1;
            state_q    <= DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            mem_req_q     <= 1'b0;
            fault_q       <= 1'b1;
            fault_cause_q <= CAUSE_TIMEOUT;
            state_q       <= FAULT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.MemReq  = mem_req_q;
  assign mem.MemAddr = mem_addr_q;
  assign IR          = ir_q;
  assign NPC         = npc_q;
  assign PCWE        = pcwe_q;
  assign IRValid     = ir_valid_q;
  assign Busy        = (state_q == REQ);
  assign Fault       = fault_q;
  assign FaultCause  = fault_cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch with hand-computed expected values.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PCIn;
  logic        Start;
  logic        Flush;
  logic [31:0] IR;
  logic [31:0] NPC;
  logic        PCWE;
  logic        IRValid;
  logic        Busy;
  logic        Fault;
  logic [1:0]  FaultCause;

  int n_vec = 0;
  int n_err = 0;
  int req_cycles;

  instr_fetch_if mem_if ();

  instr_fetch #(.TIMEOUT(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCIn       (PCIn),
    .Start      (Start),
    .Flush      (Flush),
    .mem        (mem_if),
    .IR         (IR),
    .NPC        (NPC),
    .PCWE       (PCWE),
    .IRValid    (IRValid),
    .Busy       (Busy),
    .Fault      (Fault),
    .FaultCause (FaultCause)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic launch(input logic [31:0] pc);
    PCIn  = pc;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    RST = 1'b0; PCIn = 32'h40; Start = 1'b1; Flush = 1'b0;
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'hFFFF_FFFF;

    // reset held with Start and MemAck active
    tick(2);
    chk("rst_req",     32'(mem_if.MemReq), 32'd0);
    chk("rst_addr",    mem_if.MemAddr,     32'h0);
    chk("rst_ir",      IR,                 32'h0);
    chk("rst_npc",     NPC,                32'h0);
    chk("rst_pcwe",    32'(PCWE),          32'd0);
    chk("rst_irvalid", 32'(IRValid),       32'd0);
    chk("rst_busy",    32'(Busy),          32'd0);
    chk("rst_fault",   32'(Fault),         32'd0);
    chk("rst_cause",   32'(FaultCause),    32'd0);
    RST = 1'b1; Start = 1'b0;
    tick();
    chk("idle_ack_ignored", 32'(mem_if.MemReq | IRValid | PCWE), 32'd0);
    mem_if.MemAck = 1'b0;

    // normal fetch, ack sampled on the third cycle of MemReq
    launch(32'h0000_0040);
    chk("nf_req",  32'(mem_if.MemReq), 32'd1);
    chk("nf_busy", 32'(Busy),          32'd1);
    chk("nf_addr", mem_if.MemAddr,     32'h40);
    tick(2);
    chk("nf_req_c3", 32'(mem_if.MemReq), 32'd1);
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'h8C22_0004;
    tick();
    mem_if.MemAck = 1'b0;
    chk("nf_req_low", 32'(mem_if.MemReq), 32'd0);
    chk("nf_ir",      IR,                 32'h8C22_0004);
    chk("nf_npc",     NPC,                32'h0000_0044);
    chk("nf_pcwe",    32'(PCWE),          32'd1);
    chk("nf_irvalid", 32'(IRValid),       32'd1);
    chk("nf_busy_lo", 32'(Busy),          32'd0);
    tick();
    chk("nf_pcwe_off", 32'(PCWE),    32'd0);
    chk("nf_irv_hold", 32'(IRValid), 32'd1);

    // misaligned PC
    tick();
    launch(32'h0000_0042);
    chk("mis_fault",   32'(Fault),         32'd1);
    chk("mis_cause",   32'(FaultCause),    32'd1);
    chk("mis_req",     32'(mem_if.MemReq), 32'd0);
    chk("mis_irvalid", 32'(IRValid),       32'd0);
    launch(32'h0000_0080);
    chk("mis_sticky_req",   32'(mem_if.MemReq), 32'd0);
    chk("mis_sticky_fault", 32'(Fault),         32'd1);
    Flush = 1'b1; tick(); Flush = 1'b0;
    chk("mis_flush_fault", 32'(Fault),      32'd0);
    chk("mis_flush_cause", 32'(FaultCause), 32'd0);
    chk("mis_addr_hold",   mem_if.MemAddr,  32'h40);

    // timeout: MemReq high for exactly 16 cycles
    launch(32'h0000_0100);
    req_cycles = 0;
    for (int i = 0; i < 40 && mem_if.MemReq; i++) begin
      req_cycles++;
      tick();
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd16);
    chk("to_fault",      32'(Fault),      32'd1);
    chk("to_cause",      32'(FaultCause), 32'd2);
    Flush = 1'b1; tick(); Flush = 1'b0;

    // ack on the 16th cycle beats the timeout
    launch(32'h0000_0200);
    tick(15);
    chk("to16_req", 32'(mem_if.MemReq), 32'd1);
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'h1234_5678;
    tick();
    mem_if.MemAck = 1'b0;
    chk("to16_fault", 32'(Fault),   32'd0);
    chk("to16_pcwe",  32'(PCWE),    32'd1);
    chk("to16_ir",    IR,           32'h1234_5678);
    chk("to16_npc",   NPC,          32'h0000_0204);
    tick(2);

    // address wrap
    launch(32'hFFFF_FFFC);
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'h0000_0000;
    tick();
    mem_if.MemAck = 1'b0;
    chk("wrap_npc",  NPC,        32'h0000_0000);
    chk("wrap_ir",   IR,         32'h0000_0000);
    chk("wrap_pcwe", 32'(PCWE),  32'd1);
    tick(2);

    // Flush and MemAck together in REQ
    launch(32'h0000_0300);
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'hDEAD_BEEF; Flush = 1'b1;
    tick();
    mem_if.MemAck = 1'b0; Flush = 1'b0;
    chk("ab_ir",      IR,                 32'h0000_0000);
    chk("ab_pcwe",    32'(PCWE),          32'd0);
    chk("ab_irvalid", 32'(IRValid),       32'd0);
    chk("ab_req",     32'(mem_if.MemReq), 32'd0);
    chk("ab_busy",    32'(Busy),          32'd0);
    chk("ab_addr",    mem_if.MemAddr,     32'h300);

    // reset mid-REQ, then a late ack
    launch(32'h0000_0400);
    RST = 1'b0; tick(); RST = 1'b1;
    chk("rr_req", 32'(mem_if.MemReq), 32'd0);
    mem_if.MemAck = 1'b1; mem_if.MemRData = 32'hCAFE_F00D;
    tick();
    mem_if.MemAck = 1'b0;
    chk("rr_late_irvalid", 32'(IRValid), 32'd0);
    chk("rr_late_pcwe",    32'(PCWE),    32'd0);
    chk("rr_late_ir",      IR,           32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multicycle MIPS CPU, directly downstream of the PC register. On a start pulse from the control FSM it samples the current PC, checks alignment, and issues a read to instruction memory over a req/ack handshake with a bounded wait. It then latches the returned word into the instruction register and produces PC+4 plus a one-cycle write-enable pulse for the PC's next-value path. It flags misaligned PCs and memory timeouts as sticky faults.

## Interface

- TIMEOUT, 16: maximum cycles MemReq stays high awaiting MemAck; legal range 2..255.
- CLK  in  1  clock; all state updates on posedge (PC updates on negedge, so PCIn is stable at every posedge).
- RST  in  1  reset, synchronous, active-low.
- PCIn  in  32  current PC value.
- Start  in  1  fetch request pulse from control FSM.
- Flush  in  1  abort and clear status.
- MemAck  in  1  instruction memory data-valid.
- MemRData  in  32  instruction memory read data.
- MemReq  out  1  read request to instruction memory.
- MemAddr  out  32  read address.
- IR  out  32  instruction register.
- NPC  out  32  latched fetch address + 4, feeds next-PC mux into PC DataInA.
- PCWE  out  1  one-cycle write-enable request for PC.
- IRValid  out  1  IR holds a freshly fetched instruction.
- Busy  out  1  high while in REQ.
- Fault  out  1  sticky fault flag.
- FaultCause  out  2  00 none, 01 misaligned PC, 10 memory timeout.

## Operation

- States: IDLE, REQ, DONE, FAULT. Reset → IDLE.
- IDLE: Start=1 and PCIn[1:0]=00 → MemAddr<=PCIn, MemReq<=1, wait counter<=0, IRValid<=0, go REQ. Start=1 and PCIn[1:0]≠00 → Fault<=1, FaultCause<=01, IRValid<=0, go FAULT, no memory request. MemAck in IDLE ignored.
- REQ: MemAck=1 → IR<=MemRData, NPC<=MemAddr+4 (mod 2^32; 0xFFFFFFFC→0x00000000), MemReq<=0, IRValid<=1, PCWE<=1, go DONE. No ack and counter=TIMEOUT-1 → MemReq<=0, Fault<=1, FaultCause<=10, go FAULT. Otherwise counter++.
- DONE: PCWE<=0, go IDLE. IRValid stays 1 until next accepted Start or Flush.
- FAULT: sticky; Start and MemAck ignored; leaves only via Flush or reset.
- Start in REQ/DONE/FAULT is ignored (no queuing).
- Flush (any state, highest priority below reset) → IDLE, MemReq=0, PCWE=0, IRValid=0, Fault=0, FaultCause=00; IR, NPC, MemAddr hold. Flush and MemAck in same cycle: Flush wins, IR not updated, no PCWE.
- Busy = (state==REQ).
- Reset values: MemReq, PCWE, IRValid, Busy, Fault = 0; FaultCause=00; IR, NPC, MemAddr = 0x00000000; counter 0. Reset mid-REQ drops MemReq at that edge; a late MemAck is then ignored.

## Timing

- Start sampled at edge N → MemReq, Busy high after N.
- MemAck sampled at edge N+k (k≥1) → IR, NPC, IRValid, PCWE valid after N+k; MemReq low after N+k; PCWE low after N+k+1.
- Minimum Start-to-IRValid: 2 edges. Next Start accepted at edge N+k+2 (back in IDLE).
- Timeout: with no ack, MemReq high for exactly TIMEOUT cycles; ack on the TIMEOUT-th cycle is accepted (ack beats timeout).
- Misaligned: Fault high after the edge sampling Start; MemReq never asserts.
- MemAddr and MemReq registered; no combinational path from inputs to outputs.

## Test plan

- Reset: RST=0 two cycles with Start=1, MemAck=1 → all outputs at reset values, state IDLE.
- Normal fetch: PCIn=0x00000040, Start pulse, MemAck after 3 cycles with MemRData=0x8C220004 → MemAddr=0x40, MemReq high 3 cycles, IR=0x8C220004, NPC=0x00000044, PCWE exactly 1 cycle, IRValid=1.
- Misaligned: PCIn=0x00000042, Start → Fault=1, FaultCause=01, MemReq never high; Start ignored until Flush clears.
- Timeout: TIMEOUT=16, no MemAck → MemReq high exactly 16 cycles, then Fault=1, FaultCause=10; repeat with MemAck on 16th cycle → normal completion, no fault.
- Wrap: PCIn=0xFFFFFFFC, ack data 0x00000000 → NPC=0x00000000, PCWE pulse.
- Abort: Flush and MemAck same cycle in REQ → IDLE, IR unchanged, no PCWE, IRValid=0; separately RST=0 mid-REQ → MemReq low next edge, subsequent MemAck ignored.
